// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and bus-select encodings for the LC-3 internal data bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {SRC_MDR, SRC_ALU, SRC_PC, SRC_MARMUX} bus_src_e;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_e;

    localparam logic [3:0] SEL_NONE   = 4'b0000;
    localparam logic [3:0] SEL_MDR    = 4'b0001;
    localparam logic [3:0] SEL_ALU    = 4'b0010;
    localparam logic [3:0] SEL_PC     = 4'b0100;
    localparam logic [3:0] SEL_MARMUX = 4'b1000;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Request/grant bundle between the bus drivers and the data bus arbiter.
interface data_bus_arbiter_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] lock;
    logic [N_SRC-1:0] gnt;
    logic [3:0]       databus_select;
    logic [1:0]       owner_id;
    logic             busy;
    logic             preempt_pulse;

    modport master (
        input  req, lock,
        output gnt, databus_select, owner_id, busy, preempt_pulse
    );

    modport slave (
        output req, lock,
        input  gnt, databus_select, owner_id, busy, preempt_pulse
    );
endinterface

// File: rtl/data_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching rr_ptr+1, rr_ptr+2, ... (mod N_SRC).
module rr_pick #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0]         req,
    input  logic [$clog2(N_SRC)-1:0] rr_ptr,
    output logic [N_SRC-1:0]         winner,
    output logic [$clog2(N_SRC)-1:0] winner_idx,
    output logic                     any
);
    localparam int IDX_W = $clog2(N_SRC);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        idx        = '0;
        // N_SRC is a power of two, so index wrap is plain truncation.
        for (int off = 1; off <= N_SRC; off++) begin
            idx = rr_ptr + IDX_W'(off);
            if (!any && req[idx]) begin
                any         = 1'b1;
                winner_idx  = idx;
                winner[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin owner of the LC-3 internal data bus with hold-time preemption and turnaround gaps.
module data_bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input logic                clk,
    input logic                reset_n,
    data_bus_arbiter_if.master bus
);
    localparam int IDX_W  = $clog2(N_SRC);
    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam arb_state_e RELEASE_STATE = (TURNAROUND == 0) ? ARB_IDLE : ARB_TURN;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       turn_cnt_q, turn_cnt_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    bus_src_e         owner_q, owner_d;
    logic             preempt_q, preempt_d;

    logic [N_SRC-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [N_SRC-1:0] others;
    logic             hold_expired;

    rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
        .req        (bus.req),
        .rr_ptr     (rr_ptr_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

    // NOTE: every output of this block is defaulted first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        preempt_d  = 1'b0;
        others     = bus.req;
        others[owner_q] = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_d      = pick_onehot;
                    owner_d    = bus_src_e'(pick_idx);
                    rr_ptr_d   = pick_idx;
                    hold_cnt_d = '0;
                    state_d    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                // Release wins over a coincident preempt, so the pulse stays low then.
                if (!bus.req[owner_q]) begin
                    gnt_d      = SEL_NONE;
                    turn_cnt_d = '0;
                    state_d    = RELEASE_STATE;
                end else if (hold_expired && !bus.lock[owner_q] && (others != '0)) begin
                    gnt_d      = SEL_NONE;
                    preempt_d  = 1'b1;
                    turn_cnt_d = '0;
                    state_d    = RELEASE_STATE;
                end
            end
            ARB_TURN: begin
                if (turn_cnt_q == 2'(TURNAROUND - 1)) state_d = ARB_IDLE;
                else                                  turn_cnt_d = turn_cnt_q + 2'd1;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= IDX_W'(N_SRC - 1);
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            gnt_q      <= SEL_NONE;
            owner_q    <= SRC_MDR;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            preempt_q  <= preempt_d;
        end
    end

    assign bus.gnt            = gnt_q;
    assign bus.databus_select = gnt_q;
    assign bus.owner_id       = owner_q;
    assign bus.busy           = |gnt_q;
    assign bus.preempt_pulse  = preempt_q;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: reset, round robin, preempt, lock, release/preempt collision, async reset.
module tb_data_bus_arbiter;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   compared   = 0;
    int   mismatched = 0;
    logic [3:0] prev_gnt = '0;
    int   order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_gnt;

    data_bus_arbiter_if #(.N_SRC(4)) tb_if ();

    data_bus_arbiter #(
        .N_SRC      (4),
        .MAX_HOLD   (8),
        .TURNAROUND (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (tb_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Grant must always be one-hot or zero, including across the asynchronous reset.
    always @(tb_if.gnt) begin
        compared++;
        assert ($onehot0(tb_if.gnt))
        else begin
            mismatched++;
            $error("FAIL gnt_onehot0: observed=%0h expected=onehot0", tb_if.gnt);
        end
    end

    // Ownership never moves between sources without an intervening zero cycle.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && prev_gnt != '0 && tb_if.gnt != '0)
            check("no_direct_handover", tb_if.gnt, prev_gnt);
        prev_gnt = tb_if.gnt;
    end

    initial begin
        // 1: reset with every source requesting
        reset_n      = 1'b0;
        tb_if.req    = 4'b1111;
        tb_if.lock   = 4'b0000;
        step(2);
        check("rst_gnt", tb_if.gnt, SEL_NONE);
        check("rst_busy", tb_if.busy, 1'b0);
        check("rst_sel", tb_if.databus_select, SEL_NONE);
        check("rst_owner", tb_if.owner_id, 2'd0);
        check("rst_preempt", tb_if.preempt_pulse, 1'b0);
        reset_n = 1'b1;
        step(1);
        check("first_gnt", tb_if.gnt, SEL_MDR);
        check("first_busy", tb_if.busy, 1'b1);

        // 2: round robin, each owner holds two cycles then drops for one edge
        for (int i = 0; i < 5; i++) begin
            exp_gnt = 4'b0001 << order[i];
            check("rr_gnt", tb_if.gnt, exp_gnt);
            check("rr_sel", tb_if.databus_select, exp_gnt);
            check("rr_owner", tb_if.owner_id, order[i]);
            step(1);
            check("rr_gnt_hold", tb_if.gnt, exp_gnt);
            tb_if.req[order[i]] = 1'b0;
            step(1);
            check("rr_release", tb_if.gnt, SEL_NONE);
            check("rr_release_busy", tb_if.busy, 1'b0);
            tb_if.req[order[i]] = 1'b1;
            step(1);
            check("rr_turn", tb_if.gnt, SEL_NONE);
            step(1);
        end
        tb_if.req = 4'b0000;
        step(3);
        check("rr_idle", tb_if.gnt, SEL_NONE);

        // 3: ALU preempted after 8 cycles by waiting PC
        tb_if.req = 4'b0010;
        step(1);
        check("pre_gnt", tb_if.gnt, SEL_ALU);
        for (int i = 1; i < 8; i++) begin
            step(1);
            check("pre_hold", tb_if.gnt, SEL_ALU);
            check("pre_nopulse", tb_if.preempt_pulse, 1'b0);
            if (i == 2) tb_if.req = 4'b0110;
        end
        step(1);
        check("pre_cut", tb_if.gnt, SEL_NONE);
        check("pre_pulse", tb_if.preempt_pulse, 1'b1);
        step(1);
        check("pre_gap", tb_if.gnt, SEL_NONE);
        check("pre_pulse_end", tb_if.preempt_pulse, 1'b0);
        step(1);
        check("pre_next", tb_if.gnt, SEL_PC);
        check("pre_owner", tb_if.owner_id, 2'd2);
        tb_if.req = 4'b0000;
        step(3);
        check("pre_idle", tb_if.gnt, SEL_NONE);

        // 4: locked ALU is never preempted
        tb_if.req  = 4'b0010;
        tb_if.lock = 4'b0010;
        step(1);
        check("lock_gnt", tb_if.gnt, SEL_ALU);
        tb_if.req = 4'b0110;
        for (int i = 1; i < 20; i++) begin
            step(1);
            check("lock_hold", tb_if.gnt, SEL_ALU);
            check("lock_nopulse", tb_if.preempt_pulse, 1'b0);
        end
        tb_if.req = 4'b0100;
        step(1);
        check("lock_release", tb_if.gnt, SEL_NONE);
        check("lock_release_pulse", tb_if.preempt_pulse, 1'b0);
        step(1);
        check("lock_gap", tb_if.gnt, SEL_NONE);
        step(1);
        check("lock_next", tb_if.gnt, SEL_PC);
        tb_if.lock = 4'b0000;
        tb_if.req  = 4'b0000;
        step(3);
        check("lock_idle", tb_if.gnt, SEL_NONE);

        // 5: owner releases on the same edge the preempt would fire
        tb_if.req = 4'b1000;
        step(1);
        check("sim_gnt", tb_if.gnt, SEL_MARMUX);
        tb_if.req = 4'b1001;
        for (int i = 1; i < 8; i++) begin
            step(1);
            check("sim_hold", tb_if.gnt, SEL_MARMUX);
        end
        tb_if.req = 4'b0001;
        step(1);
        check("sim_release", tb_if.gnt, SEL_NONE);
        check("sim_nopulse", tb_if.preempt_pulse, 1'b0);
        step(1);
        check("sim_gap", tb_if.gnt, SEL_NONE);
        check("sim_gap_nopulse", tb_if.preempt_pulse, 1'b0);
        step(1);
        check("sim_next", tb_if.gnt, SEL_MDR);

        // 6: asynchronous reset between edges while MDR owns the bus
        #3;
        reset_n = 1'b0;
        #1;
        check("async_gnt", tb_if.gnt, SEL_NONE);
        check("async_busy", tb_if.busy, 1'b0);
        check("async_sel", tb_if.databus_select, SEL_NONE);
        tb_if.req = 4'b0000;
        #2;
        reset_n = 1'b1;
        step(2);
        check("async_idle", tb_if.gnt, SEL_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
